// File: rtl/rtmq_extuart_fifo.sv
// RTMQ external UART (gen 2): W_REG-bit words over N_LANE serial lanes with Tx/Rx FIFOs and sticky errors.
// Optional per-lane even parity symbol between the last data symbol and stop: define EXTUART_PARITY_EN.
module rtmq_extuart_fifo #(
  parameter int W_REG  = 32,
  parameter int N_LANE = 8,
  parameter int D_TXF  = 16,
  parameter int D_RXF  = 16,
  parameter int W_BAU  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W_BAU-1:0]       cfg_baud_tx,
  input  logic [W_BAU-1:0]       cfg_baud_rx,
  input  logic [W_REG-1:0]       tx_dat,
  input  logic                   tx_wr,
  output logic                   tx_full,
  output logic [$clog2(D_TXF):0] tx_lvl,
  output logic                   f_txdn,
  output logic [W_REG-1:0]       rx_dat,
  input  logic                   rx_rd,
  output logic                   rx_empty,
  output logic                   f_rxdn,
  output logic [2:0]             err_stat,
  input  logic                   err_clr,
  input  logic [N_LANE-1:0]      exu_rx,
  output logic [N_LANE-1:0]      exu_tx
);
  localparam int N_SYM = W_REG / N_LANE;
  localparam int W_SYM = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int A_TX  = $clog2(D_TXF);
  localparam int A_RX  = $clog2(D_RXF);
  localparam logic [W_SYM-1:0]  SYM_LAST = W_SYM'(N_SYM - 1);
  localparam logic [N_LANE-1:0] LN_IDLE  = '1;
  localparam logic [A_TX:0]     TX_DEPTH = (A_TX+1)'(D_TXF);
  localparam logic [A_RX:0]     RX_DEPTH = (A_RX+1)'(D_RXF);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

`ifdef EXTUART_PARITY_EN
  function automatic logic [N_LANE-1:0] lane_par(input logic [W_REG-1:0] w);
    logic [N_LANE-1:0] p;
    p = '0;
    for (int k = 0; k < N_SYM; k++) p = p ^ w[k*N_LANE +: N_LANE];
    return p;
  endfunction
`endif

  // ---------------- Tx FIFO + Tx FSM ----------------
  logic [W_REG-1:0]  txf_mem [D_TXF];
  logic [A_TX-1:0]   txf_wp_q, txf_wp_d, txf_rp_q, txf_rp_d;
  logic [A_TX:0]     txf_cnt_q, txf_cnt_d;
  logic              tx_push, tx_pop, tx_ovf;
  logic [W_REG-1:0]  tx_head;

  state_t            tx_st_q, tx_st_d;
  logic [W_BAU-1:0]  tx_baud_q, tx_baud_d, tx_cnt_q, tx_cnt_d;
  logic [W_SYM-1:0]  tx_sym_q, tx_sym_d;
  logic [N_LANE-1:0] exu_tx_q, exu_tx_d;
  logic              txdn_p_q, txdn_p_d, f_txdn_q;
  logic              tx_tick;

  // The head word stays in the FIFO for the whole frame; it is popped when its stop symbol ends.
  assign tx_head = txf_mem[txf_rp_q];
  assign tx_full = (txf_cnt_q == TX_DEPTH);
  assign tx_tick = (tx_cnt_q == '0);
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign tx_ovf  = tx_wr && tx_full && !tx_pop;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_baud_d = tx_baud_q;
    tx_cnt_d  = tx_tick ? tx_baud_q : tx_cnt_q - W_BAU'(1);
    tx_sym_d  = tx_sym_q;
    tx_pop    = 1'b0;
    txdn_p_d  = 1'b0;
    exu_tx_d  = LN_IDLE;
    case (tx_st_q)
      S_IDLE: begin
        if (txf_cnt_q != '0) begin
          tx_st_d   = S_START;
          tx_baud_d = cfg_baud_tx;
          tx_cnt_d  = cfg_baud_tx;
        end
      end
      S_START: begin
        exu_tx_d = '0;
        if (tx_tick) begin
          tx_st_d  = S_DATA;
          tx_sym_d = '0;
        end
      end
      S_DATA: begin
        exu_tx_d = tx_head[int'(tx_sym_q)*N_LANE +: N_LANE];
        if (tx_tick) begin
          tx_sym_d = tx_sym_q + W_SYM'(1);
          if (tx_sym_q == SYM_LAST) begin
`ifdef EXTUART_PARITY_EN
            tx_st_d = S_PAR;
`else
            tx_st_d = S_STOP;
`endif
          end
        end
      end
`ifdef EXTUART_PARITY_EN
      S_PAR: begin
        exu_tx_d = lane_par(tx_head);
        if (tx_tick) tx_st_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_tick) begin
          tx_pop = 1'b1;
          if (txf_cnt_q > (A_TX+1)'(1) || tx_wr) begin
            tx_st_d   = S_START;
            tx_baud_d = cfg_baud_tx;
            tx_cnt_d  = cfg_baud_tx;
          end else begin
            tx_st_d  = S_IDLE;
            txdn_p_d = 1'b1;
          end
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    txf_wp_d  = txf_wp_q + A_TX'(tx_push);
    txf_rp_d  = txf_rp_q + A_TX'(tx_pop);
    txf_cnt_d = txf_cnt_q + (A_TX+1)'(tx_push) - (A_TX+1)'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) txf_mem[txf_wp_q] <= tx_dat;
  end

  // f_txdn is delayed one cycle so it lands on the first idle cycle of the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_st_q   <= S_IDLE;
      tx_baud_q <= '0;
      tx_cnt_q  <= '0;
      tx_sym_q  <= '0;
      exu_tx_q  <= LN_IDLE;
      txdn_p_q  <= 1'b0;
      f_txdn_q  <= 1'b0;
      txf_wp_q  <= '0;
      txf_rp_q  <= '0;
      txf_cnt_q <= '0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_baud_q <= tx_baud_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_sym_q  <= tx_sym_d;
      exu_tx_q  <= exu_tx_d;
      txdn_p_q  <= txdn_p_d;
      f_txdn_q  <= txdn_p_q;
      txf_wp_q  <= txf_wp_d;
      txf_rp_q  <= txf_rp_d;
      txf_cnt_q <= txf_cnt_d;
    end
  end

  // ---------------- Rx synchroniser + Rx FSM ----------------
  logic [N_LANE-1:0] rx_m_q, rx_s_q;
  logic              rx_prev_q;
  state_t            rx_st_q, rx_st_d;
  logic [W_BAU-1:0]  rx_baud_q, rx_baud_d, rx_cnt_q, rx_cnt_d;
  logic [W_SYM-1:0]  rx_sym_q, rx_sym_d;
  logic [W_REG-1:0]  rx_word_q, rx_word_d;
  logic              rx_perr_q, rx_perr_d;
  logic              rx_tick, rx_push, rx_ferr, rx_perr_ev;

  assign rx_tick = (rx_cnt_q == '0);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_baud_d  = rx_baud_q;
    rx_cnt_d   = rx_tick ? rx_baud_q : rx_cnt_q - W_BAU'(1);
    rx_sym_d   = rx_sym_q;
    rx_word_d  = rx_word_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    rx_perr_ev = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q[0]) begin
          rx_st_d   = S_START;
          rx_baud_d = cfg_baud_rx;
          rx_cnt_d  = (cfg_baud_rx >> 1) - W_BAU'(1);
          rx_perr_d = 1'b0;
        end
      end
      S_START: begin
        if (rx_tick) begin
          rx_st_d  = rx_s_q[0] ? S_IDLE : S_DATA;
          rx_sym_d = '0;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_word_d[int'(rx_sym_q)*N_LANE +: N_LANE] = rx_s_q;
          rx_sym_d = rx_sym_q + W_SYM'(1);
          if (rx_sym_q == SYM_LAST) begin
`ifdef EXTUART_PARITY_EN
            rx_st_d = S_PAR;
`else
            rx_st_d = S_STOP;
`endif
          end
        end
      end
`ifdef EXTUART_PARITY_EN
      S_PAR: begin
        if (rx_tick) begin
          rx_perr_d = (rx_s_q != lane_par(rx_word_q));
          rx_st_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (rx_tick) begin
          rx_perr_ev = rx_perr_q;
          if (rx_s_q != LN_IDLE) begin
            rx_ferr = 1'b1;
            rx_st_d = S_WAIT;
          end else begin
            rx_push = !rx_perr_q;
            rx_st_d = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (rx_s_q == LN_IDLE) rx_st_d = S_IDLE;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m_q    <= LN_IDLE;
      rx_s_q    <= LN_IDLE;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_baud_q <= '0;
      rx_cnt_q  <= '0;
      rx_sym_q  <= '0;
      rx_perr_q <= 1'b0;
    end else begin
      rx_m_q    <= exu_rx;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q[0];
      rx_st_q   <= rx_st_d;
      rx_baud_q <= rx_baud_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_sym_q  <= rx_sym_d;
      rx_perr_q <= rx_perr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_word_q <= rx_word_d;
  end

  // ---------------- Rx FIFO + error status ----------------
  logic [W_REG-1:0] rxf_mem [D_RXF];
  logic [A_RX-1:0]  rxf_wp_q, rxf_wp_d, rxf_rp_q, rxf_rp_d;
  logic [A_RX:0]    rxf_cnt_q, rxf_cnt_d;
  logic             rxf_push, rxf_pop, rxf_full, rx_ovf;
  logic [W_REG-1:0] rx_dat_q, rx_dat_d;
  logic             f_rxdn_q;
  logic [2:0]       err_q, err_d;

  assign rxf_full = (rxf_cnt_q == RX_DEPTH);
  assign rxf_pop  = rx_rd && (rxf_cnt_q != '0);
  assign rxf_push = rx_push && (!rxf_full || rxf_pop);
  assign rx_ovf   = rx_push && rxf_full && !rxf_pop;

  // Show-ahead head register: the word being pushed this cycle becomes the head when nothing older remains.
  always_comb begin
    rxf_wp_d  = rxf_wp_q + A_RX'(rxf_push);
    rxf_rp_d  = rxf_rp_q + A_RX'(rxf_pop);
    rxf_cnt_d = rxf_cnt_q + (A_RX+1)'(rxf_push) - (A_RX+1)'(rxf_pop);
    if (rxf_cnt_d == '0)                          rx_dat_d = rx_dat_q;
    else if (rxf_push && (rxf_rp_d == rxf_wp_q)) rx_dat_d = rx_word_q;
    else                                          rx_dat_d = rxf_mem[rxf_rp_d];
    err_d = (err_clr ? 3'b000 : err_q) | {rx_perr_ev, tx_ovf | rx_ovf, rx_ferr};
  end

  always_ff @(posedge clk) begin
    if (rxf_push) rxf_mem[rxf_wp_q] <= rx_word_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxf_wp_q  <= '0;
      rxf_rp_q  <= '0;
      rxf_cnt_q <= '0;
      rx_dat_q  <= '0;
      f_rxdn_q  <= 1'b0;
      err_q     <= 3'b000;
    end else begin
      rxf_wp_q  <= rxf_wp_d;
      rxf_rp_q  <= rxf_rp_d;
      rxf_cnt_q <= rxf_cnt_d;
      rx_dat_q  <= rx_dat_d;
      f_rxdn_q  <= rxf_push;
      err_q     <= err_d;
    end
  end

  assign tx_lvl   = txf_cnt_q;
  assign f_txdn   = f_txdn_q;
  assign exu_tx   = exu_tx_q;
  assign rx_dat   = rx_dat_q;
  assign rx_empty = (rxf_cnt_q == '0);
  assign f_rxdn   = f_rxdn_q;
  assign err_stat = err_q;

endmodule

// File: tb/tb_rtmq_extuart_fifo.sv
// Directed bench for rtmq_extuart_fifo (default parameters, 8 lanes, 32-bit words).
module tb_rtmq_extuart_fifo;
`ifdef EXTUART_PARITY_EN
  localparam int NF = 7;
`else
  localparam int NF = 6;
`endif
  localparam int FRM = NF * 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_baud_tx, cfg_baud_rx;
  logic [31:0] tx_dat;
  logic        tx_wr;
  logic        tx_full;
  logic [4:0]  tx_lvl;
  logic        f_txdn;
  logic [31:0] rx_dat;
  logic        rx_rd;
  logic        rx_empty;
  logic        f_rxdn;
  logic [2:0]  err_stat;
  logic        err_clr;
  logic [7:0]  exu_rx, exu_tx, rx_drv;
  logic        loop_en;

  assign exu_rx = loop_en ? exu_tx : rx_drv;

  rtmq_extuart_fifo #(.W_REG(32), .N_LANE(8), .D_TXF(16), .D_RXF(16), .W_BAU(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_baud_tx(cfg_baud_tx), .cfg_baud_rx(cfg_baud_rx),
    .tx_dat(tx_dat), .tx_wr(tx_wr), .tx_full(tx_full), .tx_lvl(tx_lvl), .f_txdn(f_txdn),
    .rx_dat(rx_dat), .rx_rd(rx_rd), .rx_empty(rx_empty), .f_rxdn(f_rxdn),
    .err_stat(err_stat), .err_clr(err_clr), .exu_rx(exu_rx), .exu_tx(exu_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nrx = 0;
  int ntx = 0;
  int rxcyc [64];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (f_rxdn) begin
      if (nrx < 64) rxcyc[nrx] <= cyc;
      nrx <= nrx + 1;
    end
    if (f_txdn) ntx <= ntx + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (nrx < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(tag, nrx, n);
  endtask

  // Symbols are packed LSB byte first; each held for per cycles on the Rx lines.
  task automatic drive_frame(input logic [63:0] syms, input int n, input int per);
    for (int i = 0; i < n; i++) begin
      rx_drv = syms[i*8 +: 8];
      repeat (per) @(negedge clk);
    end
    rx_drv = 8'hFF;
  endtask

  logic [63:0] deadbeef_syms, bad_stop, good_frame;
  logic [31:0] vals [17];
  int n0, t0;

  initial begin
`ifdef EXTUART_PARITY_EN
    deadbeef_syms = 64'h00FF_22DE_ADBE_EF00;
    bad_stop      = 64'h00F7_4444_3322_1100;
    good_frame    = 64'h00FF_0812_3456_7800;
`else
    deadbeef_syms = 64'h0000_FFDE_ADBE_EF00;
    bad_stop      = 64'h0000_F744_3322_1100;
    good_frame    = 64'h0000_FF12_3456_7800;
`endif
    rst_n = 1'b0; cfg_baud_tx = 16'd4; cfg_baud_rx = 16'd4; tx_dat = '0; tx_wr = 1'b0;
    rx_rd = 1'b0; err_clr = 1'b0; rx_drv = 8'hFF; loop_en = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_exu_tx", exu_tx, 8'hFF);
    chk("rst_rx_empty", rx_empty, 1'b1);
    chk("rst_tx_lvl", tx_lvl, 5'd0);
    chk("rst_err", err_stat, 3'b000);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_rx_dat", rx_dat, 32'h0);

    // Loopback, one word, baud 4/4
    tx_dat = 32'hDEADBEEF; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    @(negedge clk);
    chk("lb_pre_start", exu_tx, 8'hFF);
    repeat (3) @(negedge clk);
    for (int k = 0; k < NF; k++) begin
      chk($sformatf("lb_sym%0d", k), exu_tx, deadbeef_syms[k*8 +: 8]);
      if (k < NF - 1) repeat (5) @(negedge clk);
    end
    chk("lb_txdn_early", f_txdn, 1'b0);
    repeat (3) @(negedge clk);
    chk("lb_txdn", f_txdn, 1'b1);
    chk("lb_idle", exu_tx, 8'hFF);
    @(negedge clk);
    chk("lb_txdn_off", f_txdn, 1'b0);
    wait_rx("lb_rx_wait", 1, 60);
    chk("lb_rx_dat", rx_dat, 32'hDEADBEEF);
    chk("lb_rx_nonempty", rx_empty, 1'b0);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    chk("lb_rx_popped", rx_empty, 1'b1);
    repeat (10) @(negedge clk);
    chk("lb_ntx", ntx, 1);
    chk("lb_nrx", nrx, 1);

    // Baud 0 on Tx: one cycle per symbol
    loop_en = 1'b0; cfg_baud_tx = 16'd0;
    tx_dat = 32'h04030201; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    @(negedge clk);
    chk("b0_pre", exu_tx, 8'hFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("b0_sym%0d", k), exu_tx, (k == 0) ? 8'h00 : 8'(k));
    end
`ifdef EXTUART_PARITY_EN
    @(negedge clk);
    chk("b0_par", exu_tx, 8'h04);
`endif
    @(negedge clk);
    chk("b0_stop", exu_tx, 8'hFF);
    @(negedge clk);
    chk("b0_txdn", f_txdn, 1'b1);
    chk("b0_lvl", tx_lvl, 5'd0);
    repeat (5) @(negedge clk);
    cfg_baud_tx = 16'd4; loop_en = 1'b1;
    repeat (5) @(negedge clk);

    // Burst of 17 words into a 16-deep Tx FIFO
    n0 = nrx; t0 = ntx;
    for (int i = 0; i < 17; i++) begin
      vals[i] = 32'h9E37_79B9 ^ (i * 32'h0101_0301);
      tx_dat = vals[i]; tx_wr = 1'b1;
      @(negedge clk);
    end
    tx_wr = 1'b0;
    chk("burst_lvl_peak", tx_lvl, 5'd16);
    chk("burst_full", tx_full, 1'b1);
    chk("burst_ovf", err_stat, 3'b010);
    wait_rx("burst_rx_wait", n0 + 16, 16 * FRM + 100);
    for (int i = 1; i < 16; i++)
      chk($sformatf("burst_gap%0d", i), rxcyc[n0 + i] - rxcyc[n0 + i - 1], FRM);
    repeat (10) @(negedge clk);
    chk("burst_ntx", ntx - t0, 1);
    chk("burst_tx_lvl", tx_lvl, 5'd0);
    rx_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("burst_word%0d", i), rx_dat, vals[i]);
      @(negedge clk);
    end
    rx_rd = 1'b0;
    chk("burst_drained", rx_empty, 1'b1);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    chk("rd_on_empty", rx_empty, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_ovf", err_stat, 3'b000);

    // Directly driven Rx frames
    loop_en = 1'b0; rx_drv = 8'hFF; cfg_baud_rx = 16'd6;
    repeat (5) @(negedge clk);
    n0 = nrx;
    drive_frame(good_frame, NF, 7);
    wait_rx("man_rx_wait", n0 + 1, 40);
    chk("man_rx_dat", rx_dat, 32'h12345678);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    cfg_baud_rx = 16'd4;
    repeat (5) @(negedge clk);
    n0 = nrx;
    drive_frame(bad_stop, NF, 5);
    repeat (15) @(negedge clk);
    chk("ferr_stat", err_stat, 3'b001);
    chk("ferr_empty", rx_empty, 1'b1);
    chk("ferr_no_push", nrx, n0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ferr_clr", err_stat, 3'b000);
`ifdef EXTUART_PARITY_EN
    drive_frame(64'h00FF_6444_3322_1100, NF, 5);
    repeat (15) @(negedge clk);
    chk("perr_stat", err_stat, 3'b100);
    chk("perr_empty", rx_empty, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
`endif

    // Reset in the middle of data symbol 2
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    n0 = nrx; t0 = ntx;
    tx_dat = 32'hDEADBEEF; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (18) @(negedge clk);
    chk("mid_sym2", exu_tx, 8'hAD);
    chk("mid_lvl", tx_lvl, 5'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_tx", exu_tx, 8'hFF);
    chk("mid_rst_lvl", tx_lvl, 5'd0);
    chk("mid_rst_empty", rx_empty, 1'b1);
    repeat (60) @(negedge clk);
    chk("mid_no_txdn", ntx, t0);
    chk("mid_no_rx", nrx, n0);
    chk("mid_idle", exu_tx, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
